// File: rtl/spi_cfg_regbank.sv
// spi_cfg_regbank: SPI mode-0 slave configuration register bank, oversampled
// on the system clock. A frame is one command byte (R/W bit + address),
// followed by data words that auto-increment the address.
// Optional lock bit: define SPI_REGBANK_LOCK_EN. Bit 0 of the last register
// then blocks writes to every other register while it is set.
module spi_cfg_regbank #(
    parameter int                          NUM_REGS    = 4,
    parameter int                          DATA_W      = 32,
    parameter int                          ADDR_W      = 7,
    parameter logic [NUM_REGS-1:0]         RO_MASK     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VALUE = '0,
    parameter int                          SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    input  logic [NUM_REGS*DATA_W-1:0]    status_in,
    output logic [NUM_REGS*DATA_W-1:0]    regs_out,
    output logic [NUM_REGS-1:0]           wr_strobe,
    output logic                          err_addr
);

    localparam int CNT_MAX = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                           state, state_nx;
    logic [SYNC_STAGES:0]             sck_q;
    logic [SYNC_STAGES-1:0]           cs_q, mosi_q;
    logic                             sck_rise, sck_fall, cs_s, mosi_s, armed;
    logic [CNT_W-1:0]                 bit_cnt;
    logic [ADDR_W-1:0]                cmd_sr, addr, addr_inc, ld_addr;
    logic [ADDR_W:0]                  cmd_next;
    logic                             rw, cmd_done, word_done, rd_load, ld_oor;
    logic [DATA_W-1:0]                rx_sr, rx_next, tx_sr, rd_data;
    logic                             commit_vld, commit_oor, lock_blk;
    logic [ADDR_W-1:0]                commit_addr;
    logic [DATA_W-1:0]                commit_data;
    logic [NUM_REGS-1:0]              wr_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;

    // Synchronisers; SCK gets one extra stage so its edges can be detected.
    // CS_N resets low so a frame already in flight cannot be joined until
    // CS has actually been seen high (see armed).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[SYNC_STAGES-1:0], spi_sck};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];

    // Only start frames after CS has been seen deasserted since reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     armed <= 1'b0;
        else if (cs_s) armed <= 1'b1;
    end

    assign cmd_next  = {cmd_sr, mosi_s};
    assign rx_next   = {rx_sr[DATA_W-2:0], mosi_s};
    assign addr_inc  = addr + 1'b1;
    assign cmd_done  = (state == CMD) && sck_rise && !cs_s && (bit_cnt == CNT_W'(ADDR_W));
    // A word completing in the same cycle CS rises still commits.
    assign word_done = (state == DATA) && sck_rise && (bit_cnt == CNT_W'(DATA_W - 1));
    assign rd_load   = (cmd_done && cmd_next[ADDR_W]) || (word_done && rw);
    assign ld_addr   = cmd_done ? cmd_next[ADDR_W-1:0] : addr_inc;
    assign ld_oor    = {1'b0, ld_addr} >= (ADDR_W + 1)'(NUM_REGS);

    // Readback snapshot: status for read-only slots, register otherwise, 0 out of range.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ld_addr == ADDR_W'(i))
                rd_data = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs[i];
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state; CS deassert wins from any state.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (armed && !cs_s) state_nx = CMD;
            CMD:     if (cmd_done)       state_nx = DATA;
            default: state_nx = state;
        endcase
        if (cs_s) state_nx = IDLE;
    end

    // Shift/count datapath and the registered write request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            addr        <= '0;
            rw          <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            commit_vld  <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
        end else begin
            commit_vld <= word_done && !rw;
            if (word_done) begin
                commit_addr <= addr;
                commit_data <= rx_next;
            end
            if (state == CMD && sck_rise) begin
                cmd_sr  <= cmd_next[ADDR_W-1:0];
                bit_cnt <= cmd_done ? '0 : bit_cnt + 1'b1;
            end
            if (cmd_done) begin
                addr <= cmd_next[ADDR_W-1:0];
                rw   <= cmd_next[ADDR_W];
            end
            if (state == DATA && sck_rise) begin
                rx_sr   <= rx_next;
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) addr <= addr_inc;
            end
            if (rd_load) begin
                tx_sr <= rd_data;
            end else if (state == DATA && rw && sck_fall && !cs_s) begin
                spi_miso    <= tx_sr[DATA_W-1];
                tx_sr       <= tx_sr << 1;
                spi_miso_oe <= 1'b1;
            end
            if (cs_s) begin
                bit_cnt     <= '0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end
        end
    end

    assign commit_oor = {1'b0, commit_addr} >= (ADDR_W + 1)'(NUM_REGS);
`ifdef SPI_REGBANK_LOCK_EN
    assign lock_blk = regs[NUM_REGS-1][0] && (commit_addr != ADDR_W'(NUM_REGS - 1));
`else
    assign lock_blk = 1'b0;
`endif

    // Per-register storage and write strobe.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign wr_hit[gi] = commit_vld && !lock_blk && !RO_MASK[gi] &&
                            (commit_addr == ADDR_W'(gi));
        // Commit the word one cycle after word completion.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                regs[gi]      <= RESET_VALUE[gi*DATA_W +: DATA_W];
                wr_strobe[gi] <= 1'b0;
            end else begin
                wr_strobe[gi] <= wr_hit[gi];
                if (wr_hit[gi]) regs[gi] <= commit_data;
            end
        end
    end

    assign regs_out = regs;

    // Sticky range error; setting has priority over the reg-0 clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_addr <= 1'b0;
        else if ((rd_load && ld_oor) || (commit_vld && commit_oor && !lock_blk))
            err_addr <= 1'b1;
        else if (wr_hit[0])
            err_addr <= 1'b0;
    end

endmodule

// File: doc/spi_cfg_regbank.md
Name: spi_cfg_regbank

Overview:
Parametrised SPI-slave configuration register bank, fully synchronous to a system clock. SCK, CS_N and MOSI are oversampled through synchronisers. Generalises the PLL control-register interface:
- N registers of configurable width.
- Per-register read-only status mapping.
- Burst auto-increment.
- Out-of-range error flag.
It feeds flat register outputs to analog/clock blocks (PLL, DCO trim) and pulses per-register write strobes.

Parameters:
NUM_REGS, 4, number of registers (1..2^ADDR_W).
DATA_W, 32, register and SPI data word width (8..32).
ADDR_W, 7, address bits in the command byte; command = 1 R/W bit + ADDR_W bits.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes reg i read-only, with reads returning status_in slice i.
RESET_VALUE, 0, NUM_REGS*DATA_W flat reset image (reg i at [i*DATA_W +: DATA_W]).
SYNC_STAGES, 2, synchroniser depth for spi_sck/spi_cs_n/spi_mosi (>=2).

Ports:
clock  input  1  system clock; must be >= 4x SCK frequency.
reset  input  1  asynchronous, active-high reset.
spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
spi_cs_n  input  1  chip select, active low.
spi_mosi  input  1  serial data in, MSB first.
spi_miso  output  1  serial data out, MSB first.
spi_miso_oe  output  1  high while a read data phase is active.
status_in  input  NUM_REGS*DATA_W  read-only status values (used where RO_MASK=1).
regs_out  output  NUM_REGS*DATA_W  current writable register contents.
wr_strobe  output  NUM_REGS  one-cycle pulse per register on each committed write.
err_addr  output  1  sticky flag: access to address >= NUM_REGS; cleared on reset or by a write to reg 0.

Behaviour:
- Reset (async, high):
  - regs_out = RESET_VALUE; wr_strobe = 0; err_addr = 0.
  - spi_miso = 0; spi_miso_oe = 0.
  - FSM = IDLE; bit counter, address and shift registers = 0.
  - Reset mid-frame aborts the frame. Nothing commits until CS is re-asserted after reset release.
- Sampling:
  - SCK, CS_N and MOSI each pass through SYNC_STAGES flops; one extra flop gives edge detection.
  - SCK rise (synced) samples MOSI. SCK fall (synced) updates MISO.
  - Total input latency = SYNC_STAGES+1 clock cycles.
- FSM (IDLE, CMD, DATA):
  - IDLE: synced CS_N low -> CMD, bit counter = 0.
  - CMD: shift 1+ADDR_W bits; first bit is R/W (1 = read). After the last bit: latch addr and rw, enter DATA; if read, load shreg from the current address.
  - DATA: count DATA_W bits per word. At the last-bit rising edge the word completes:
    - write: commit the word to addr;
    - read: reload shreg from addr+1;
    - then addr <= addr+1 (wraps at 2^ADDR_W); stay in DATA (burst).
  - Any state: synced CS_N high -> IDLE; partial command/word discarded, never committed; spi_miso_oe = 0, spi_miso = 0.
- Write commit: on the clock after word-complete detection, reg[addr] is updated and wr_strobe[addr] = 1 for exactly one cycle.
  - Addr >= NUM_REGS: ignored, err_addr <= 1.
  - RO_MASK[addr] = 1: ignored, no strobe, no error.
  - Write to reg 0 also clears err_addr; if the same word is out of range, set wins (not possible for reg 0).
- Read data:
  - Readback = status_in slice if RO_MASK=1, else the register; 0 and err_addr <= 1 if addr >= NUM_REGS.
  - Snapshot taken at shreg load.
  - On each SCK fall in a read DATA phase: spi_miso <= shreg[DATA_W-1], shreg <<= 1. spi_miso_oe is high from the first such fall until CS deasserts.
- Simultaneous events:
  - Word-complete and CS deassert detected in the same cycle: the word commits, then IDLE.
  - wr_strobe for consecutive burst words is never merged, since words are >= 4*DATA_W clocks apart.
- regs_out is a direct register output: no combinational path from SPI inputs.

Optional Feature:
Macro SPI_REGBANK_LOCK_EN.
- Defined: bit 0 of reg NUM_REGS-1 is a lock bit. While it is 1, writes to every other register are ignored: no strobe, err_addr unchanged. Reg NUM_REGS-1 itself stays writable, so the lock can be cleared. Reset clears the lock per RESET_VALUE.
- Undefined: no lock logic; reg NUM_REGS-1 is ordinary.

Test Plan:
- Defaults: after reset, write cmd 0x00 + data 0x0000_0015 -> regs_out[31:0] = 0x15; wr_strobe[0] pulses exactly 1 cycle; all other regs keep RESET_VALUE.
- Burst: write cmd 0x01, then 3 words 0xA, 0xB, 0xC -> regs 1, 2, 3 = 0xA, 0xB, 0xC; three separate strobes; no error.
- Read with RO: RO_MASK = 4'b0100, status_in reg2 = 0xDEAD_BEEF; read cmd 0x82 -> MISO shifts 0xDEADBEEF MSB first; a write to reg 2 produces no strobe and leaves it unchanged.
- Range error: write cmd 0x05 (NUM_REGS=4) -> no strobe, err_addr = 1; read 0x85 returns 0; a write to reg 0 clears err_addr.
- Abort: CS_N rises after 20 of 32 data bits -> no register change, no strobe; the next full frame works normally.
- Lock (SPI_REGBANK_LOCK_EN): write reg 3 = 0x1, then write reg 0 = 0xFF -> reg 0 unchanged; write reg 3 = 0, retry -> reg 0 = 0xFF.
